// File: rtl/sb_axil_pkg.sv
// Shared constants for the AXI-lite outstanding-transaction slave bridge:
// response codes, the W/R tag type and the req/resp field layout.
package sb_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    TAG_W = 1'b0,
    TAG_R = 1'b1
  } tag_e;

  // resp_data = {resp, rdata}
  localparam int RESP_RDATA_LSB = 0;
  function automatic int resp_code_lsb(input int dw);
    return dw;
  endfunction

  // req_data = {is_write, prot, addr, strb, data}
  localparam int REQ_DATA_LSB = 0;
  function automatic int req_strb_lsb(input int dw);
    return dw;
  endfunction
  function automatic int req_addr_lsb(input int dw, input int sw);
    return dw + sw;
  endfunction
  function automatic int req_prot_lsb(input int dw, input int sw, input int aw);
    return dw + sw + aw;
  endfunction
  function automatic int req_is_write_bit(input int dw, input int sw, input int aw);
    return dw + sw + aw + 3;
  endfunction

endpackage

// File: rtl/sb_axil_tag_fifo.sv
// In-order W/R tag FIFO; pointers wrap modulo DEPTH so any depth works,
// not only powers of two.
module sb_axil_tag_fifo
  import sb_axil_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          din,
  output logic          dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic          r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sb_axil_s_ot.sv
// AXI-lite slave to req/resp bridge with bounded outstanding transactions.
// Define SB_AXIL_S_OT_TIMEOUT_EN to add the response timeout / late-beat drop logic.
module sb_axil_s_ot
  import sb_axil_pkg::*;
#(
  parameter  int DATA_WIDTH      = 32,
  parameter  int ADDR_WIDTH      = 16,
  parameter  int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter  int MAX_OUTSTANDING = 4,
  parameter  int TIMEOUT_CYCLES  = 1024,
  localparam int CW              = $clog2(MAX_OUTSTANDING + 1),
  localparam int REQ_W           = 1 + 3 + ADDR_WIDTH + STRB_WIDTH + DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [REQ_W-1:0]      req_data,
  output logic                  req_valid,
  input  logic                  req_ready,
  input  logic [DATA_WIDTH+1:0] resp_data,
  input  logic                  resp_valid,
  output logic                  resp_ready,
  output logic [CW-1:0]         outstanding
);

  localparam int RESP_CODE_LSB = resp_code_lsb(DATA_WIDTH);

  logic                  r_prio_rd;
  logic                  w_wr_elig;
  logic                  w_rd_elig;
  logic                  w_sel_rd;
  logic                  w_req_hs;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_head_bit;
  tag_e                  w_head;
  logic                  w_local;
  logic                  w_dropping;
  logic                  w_route_valid;
  logic [1:0]            w_resp_code;
  logic [DATA_WIDTH-1:0] w_resp_rdata;

  // Request side: fully combinational, write and read share one req port.
  always_comb begin
    w_wr_elig      = s_axil_awvalid & s_axil_wvalid;
    w_rd_elig      = s_axil_arvalid;
    w_sel_rd       = (w_wr_elig & w_rd_elig) ? r_prio_rd : w_rd_elig;
    req_valid      = ~reset & (w_wr_elig | w_rd_elig) & ~w_full;
    w_req_hs       = req_valid & req_ready;
    s_axil_awready = w_req_hs & ~w_sel_rd;
    s_axil_wready  = w_req_hs & ~w_sel_rd;
    s_axil_arready = w_req_hs & w_sel_rd;
    if (w_sel_rd)
      req_data = {1'b0, s_axil_arprot, s_axil_araddr, {STRB_WIDTH{1'b0}}, {DATA_WIDTH{1'b0}}};
    else
      req_data = {1'b1, s_axil_awprot, s_axil_awaddr, s_axil_wstrb, s_axil_wdata};
  end

  always_ff @(posedge clk) begin
    if (reset)         r_prio_rd <= 1'b0;
    else if (w_req_hs) r_prio_rd <= ~r_prio_rd;
  end

  sb_axil_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_req_hs),
    .pop   (w_pop),
    .din   (w_sel_rd),
    .dout  (w_head_bit),
    .full  (w_full),
    .empty (w_empty),
    .count (outstanding)
  );

  assign w_head       = tag_e'(w_head_bit);
  assign w_resp_code  = resp_data[RESP_CODE_LSB +: 2];
  assign w_resp_rdata = resp_data[RESP_RDATA_LSB +: DATA_WIDTH];

`ifdef SB_AXIL_S_OT_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DCW = CW + 2;

  logic [TCW-1:0] r_to_cnt;
  logic [DCW-1:0] r_drop_cnt;
  logic           w_drop_inc;
  logic           w_drop_dec;

  assign w_local    = ~w_empty & (r_to_cnt == TCW'(TIMEOUT_CYCLES));
  assign w_dropping = (r_drop_cnt != '0);
  assign w_drop_inc = w_pop & w_local;
  assign w_drop_dec = w_dropping & resp_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_to_cnt   <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_pop)
        r_to_cnt <= '0;
      else if (~w_empty && !w_local)
        r_to_cnt <= r_to_cnt + 1'b1;
      // Each timed-out transaction owes the system exactly one late beat to swallow.
      if (w_drop_inc && !w_drop_dec && r_drop_cnt != '1)
        r_drop_cnt <= r_drop_cnt + 1'b1;
      else if (w_drop_dec && !w_drop_inc)
        r_drop_cnt <= r_drop_cnt - 1'b1;
    end
  end
`else
  assign w_local    = 1'b0;
  assign w_dropping = 1'b0;
`endif

  assign w_route_valid = w_local | (resp_valid & ~w_dropping);

  // Response side: the head tag steers the shared resp channel to B or R.
  always_comb begin
    s_axil_bvalid = 1'b0;
    s_axil_rvalid = 1'b0;
    s_axil_bresp  = w_local ? RESP_SLVERR : w_resp_code;
    s_axil_rresp  = w_local ? RESP_SLVERR : w_resp_code;
    s_axil_rdata  = w_local ? {DATA_WIDTH{1'b0}} : w_resp_rdata;
    if (!reset && !w_empty) begin
      if (w_head == TAG_W) s_axil_bvalid = w_route_valid;
      else                 s_axil_rvalid = w_route_valid;
    end
    w_pop      = (s_axil_bvalid & s_axil_bready) | (s_axil_rvalid & s_axil_rready);
    resp_ready = ~reset & (w_dropping |
                 (~w_empty & ~w_local & ((w_head == TAG_W) ? s_axil_bready : s_axil_rready)));
  end

endmodule
